// File: rtl/lsu_arb_pkg.sv
// lsu_arb_pkg: shared types and constants for the LSU port arbiter.
// Used by rr_grant2 and lsu_arbiter.
package lsu_arb_pkg;

  localparam int LSU_ARB_MASTERS = 2;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wren;
    logic [2:0]  load_type;
    logic [1:0]  store_type;
  } lsu_req_t;

  function automatic lsu_req_t lsu_idle();
    return '0;
  endfunction

endpackage

// File: rtl/rr_grant2.sv
// rr_grant2: two-way round-robin grant with a priority pointer.
// Masked-out requesters are never granted.
module rr_grant2
  import lsu_arb_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [1:0] i_req,
  input  logic [1:0] i_mask,
  output logic [1:0] o_gnt
);

  logic       r_prio;
  logic [1:0] w_req;

  assign w_req = i_req & i_mask;

  // lone requester wins; on conflict the pointer decides
  always_comb begin
    o_gnt = w_req;
    if (&w_req)
      o_gnt = r_prio ? 2'b10 : 2'b01;
  end

  // after a grant to master n the other master gets priority
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)
      r_prio <= 1'b0;
    else if (o_gnt[0])
      r_prio <= 1'b1;
    else if (o_gnt[1])
      r_prio <= 1'b0;
  end

endmodule

// File: rtl/lsu_arbiter.sv
// lsu_arbiter: shares one LSU port between two masters (round robin).
// Optional lock mode is built when LSU_ARB_LOCK_EN is defined.
module lsu_arbiter
  import lsu_arb_pkg::*;
#(
  parameter int LOCK_MAX = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_m0_req,
  input  logic [31:0] i_m0_addr,
  input  logic [31:0] i_m0_wdata,
  input  logic        i_m0_wren,
  input  logic [2:0]  i_m0_load_type,
  input  logic [1:0]  i_m0_store_type,
  input  logic        i_m0_lock,
  input  logic        i_m1_req,
  input  logic [31:0] i_m1_addr,
  input  logic [31:0] i_m1_wdata,
  input  logic        i_m1_wren,
  input  logic [2:0]  i_m1_load_type,
  input  logic [1:0]  i_m1_store_type,
  input  logic        i_m1_lock,
  output logic        o_m0_gnt,
  output logic        o_m1_gnt,
  output logic        o_m0_rvalid,
  output logic        o_m1_rvalid,
  output logic [31:0] o_m0_rdata,
  output logic [31:0] o_m1_rdata,
  output logic [31:0] o_lsu_addr,
  output logic [31:0] o_st_data,
  output logic        o_lsu_wren,
  output logic [2:0]  o_load_type,
  output logic [1:0]  o_store_type,
  input  logic [31:0] i_ld_data
);

  lsu_req_t    w_m0;
  lsu_req_t    w_m1;
  lsu_req_t    w_lsu;
  logic [1:0]  w_req;
  logic [1:0]  w_mask;
  logic [1:0]  w_gnt;
  logic [1:0]  r_rvalid;
  logic [31:0] r_rdata0;
  logic [31:0] r_rdata1;

  assign w_m0 = '{addr: i_m0_addr, wdata: i_m0_wdata,
                  wren: i_m0_wren, load_type: i_m0_load_type,
                  store_type: i_m0_store_type};
  assign w_m1 = '{addr: i_m1_addr, wdata: i_m1_wdata,
                  wren: i_m1_wren, load_type: i_m1_load_type,
                  store_type: i_m1_store_type};

  assign w_req = {i_m1_req, i_m0_req};

  rr_grant2 u_rr (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_req   (w_req),
    .i_mask  (w_mask),
    .o_gnt   (w_gnt)
  );

`ifdef LSU_ARB_LOCK_EN
  localparam logic [7:0] LMAX = 8'(LOCK_MAX);

  arb_state_e r_state;
  arb_state_e w_state_nxt;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_nxt;

  // lock state and granted-cycle counter
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ARB;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // enter lock on a locked grant; leave on lock drop or max count
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      ARB: begin
        if (w_gnt[0] && i_m0_lock) begin
          w_state_nxt = LOCK0;
          w_cnt_nxt   = 8'd1;
        end else if (w_gnt[1] && i_m1_lock) begin
          w_state_nxt = LOCK1;
          w_cnt_nxt   = 8'd1;
        end
      end
      LOCK0: begin
        if (!i_m0_lock ||
            (w_gnt[0] && (r_cnt + 8'd1 == LMAX))) begin
          w_state_nxt = ARB;
          w_cnt_nxt   = 8'd0;
        end else if (w_gnt[0]) begin
          w_cnt_nxt   = r_cnt + 8'd1;
        end
      end
      LOCK1: begin
        if (!i_m1_lock ||
            (w_gnt[1] && (r_cnt + 8'd1 == LMAX))) begin
          w_state_nxt = ARB;
          w_cnt_nxt   = 8'd0;
        end else if (w_gnt[1]) begin
          w_cnt_nxt   = r_cnt + 8'd1;
        end
      end
      default: begin
        w_state_nxt = ARB;
        w_cnt_nxt   = 8'd0;
      end
    endcase
  end

  // only the lock owner may be granted while locked
  always_comb begin
    w_mask = 2'b11;
    unique case (r_state)
      LOCK0:   w_mask = 2'b01;
      LOCK1:   w_mask = 2'b10;
      default: w_mask = 2'b11;
    endcase
  end
`else
  logic w_unused_lock;

  assign w_mask        = 2'b11;
  assign w_unused_lock = i_m0_lock ^ i_m1_lock;
`endif

  // drive the LSU with the granted master, idle zeros otherwise
  always_comb begin
    w_lsu = lsu_idle();
    unique case (1'b1)
      w_gnt[0]: w_lsu = w_m0;
      w_gnt[1]: w_lsu = w_m1;
      default:  w_lsu = lsu_idle();
    endcase
  end

  assign o_lsu_addr   = w_lsu.addr;
  assign o_st_data    = w_lsu.wdata;
  assign o_lsu_wren   = w_lsu.wren;
  assign o_load_type  = w_lsu.load_type;
  assign o_store_type = w_lsu.store_type;

  assign o_m0_gnt = w_gnt[0];
  assign o_m1_gnt = w_gnt[1];

  // capture load data for the granted master, one-cycle rvalid
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rvalid <= 2'b00;
      r_rdata0 <= 32'd0;
      r_rdata1 <= 32'd0;
    end else begin
      r_rvalid <= w_gnt & ~{i_m1_wren, i_m0_wren};
      if (w_gnt[0] && !i_m0_wren)
        r_rdata0 <= i_ld_data;
      if (w_gnt[1] && !i_m1_wren)
        r_rdata1 <= i_ld_data;
    end
  end

  assign o_m0_rvalid = r_rvalid[0];
  assign o_m1_rvalid = r_rvalid[1];
  assign o_m0_rdata  = r_rdata0;
  assign o_m1_rdata  = r_rdata1;

endmodule

// File: tb/tb_lsu_arbiter.sv
// tb_lsu_arbiter: directed self-checking bench for lsu_arbiter.
// Lock scenarios run when LSU_ARB_LOCK_EN is defined.
module tb_lsu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m1_req;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic        m0_wren, m1_wren;
  logic [2:0]  m0_lt, m1_lt;
  logic [1:0]  m0_st, m1_st;
  logic        m0_lock, m1_lock;
  logic        m0_gnt, m1_gnt, m0_rv, m1_rv;
  logic [31:0] m0_rd, m1_rd;
  logic [31:0] lsu_addr, st_data, ld_data;
  logic        lsu_wren;
  logic [2:0]  load_type;
  logic [1:0]  store_type;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsu_arbiter #(.LOCK_MAX(4)) dut (
    .i_clk           (clk),
    .i_reset         (rst),
    .i_m0_req        (m0_req),
    .i_m0_addr       (m0_addr),
    .i_m0_wdata      (m0_wdata),
    .i_m0_wren       (m0_wren),
    .i_m0_load_type  (m0_lt),
    .i_m0_store_type (m0_st),
    .i_m0_lock       (m0_lock),
    .i_m1_req        (m1_req),
    .i_m1_addr       (m1_addr),
    .i_m1_wdata      (m1_wdata),
    .i_m1_wren       (m1_wren),
    .i_m1_load_type  (m1_lt),
    .i_m1_store_type (m1_st),
    .i_m1_lock       (m1_lock),
    .o_m0_gnt        (m0_gnt),
    .o_m1_gnt        (m1_gnt),
    .o_m0_rvalid     (m0_rv),
    .o_m1_rvalid     (m1_rv),
    .o_m0_rdata      (m0_rd),
    .o_m1_rdata      (m1_rd),
    .o_lsu_addr      (lsu_addr),
    .o_st_data       (st_data),
    .o_lsu_wren      (lsu_wren),
    .o_load_type     (load_type),
    .o_store_type    (store_type),
    .i_ld_data       (ld_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    m0_req = 0; m1_req = 0; m0_lock = 0; m1_lock = 0;
    m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0;
    m0_wren = 0; m1_wren = 0; m0_lt = 0; m1_lt = 0;
    m0_st = 0; m1_st = 0; ld_data = 0;
    step();
    step();
    rst = 1'b0;

    chk("rst_m0_rvalid", {31'd0, m0_rv}, 32'd0);
    chk("rst_m1_rvalid", {31'd0, m1_rv}, 32'd0);
    chk("rst_m0_rdata", m0_rd, 32'd0);
    chk("rst_m1_rdata", m1_rd, 32'd0);
    chk("idle_addr", lsu_addr, 32'd0);
    chk("idle_wren", {31'd0, lsu_wren}, 32'd0);

    // single m0 load
    m0_req = 1; m0_addr = 32'h10; m0_lt = 3'd2;
    ld_data = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("ld_m0_gnt", {31'd0, m0_gnt}, 32'd1);
    chk("ld_m1_gnt", {31'd0, m1_gnt}, 32'd0);
    chk("ld_addr", lsu_addr, 32'h10);
    chk("ld_ltype", {29'd0, load_type}, 32'd2);
    chk("ld_wren", {31'd0, lsu_wren}, 32'd0);
    step();
    m0_req = 0;
    chk("ld_m0_rvalid", {31'd0, m0_rv}, 32'd1);
    chk("ld_m0_rdata", m0_rd, 32'hDEAD_BEEF);
    chk("ld_m1_rvalid", {31'd0, m1_rv}, 32'd0);
    chk("ld_m1_rdata", m1_rd, 32'd0);
    @(negedge clk);
    chk("ld_gnt_off", {30'd0, m1_gnt, m0_gnt}, 32'd0);
    step();
    chk("ld_rvalid_1cyc", {31'd0, m0_rv}, 32'd0);
    chk("ld_rdata_hold", m0_rd, 32'hDEAD_BEEF);

    // reset pulse so round robin starts from m0
    rst = 1'b1;
    #1;
    rst = 1'b0;

    // both masters request continuously
    m0_req = 1; m1_req = 1;
    m0_addr = 32'hA0; m1_addr = 32'hB0;
    for (int i = 0; i < 6; i++) begin
      logic e0;
      e0 = (i % 2 == 0);
      ld_data = 32'h100 + 32'(i);
      @(negedge clk);
      chk("rr_m0_gnt", {31'd0, m0_gnt}, {31'd0, e0});
      chk("rr_m1_gnt", {31'd0, m1_gnt}, {31'd0, !e0});
      chk("rr_addr", lsu_addr, e0 ? 32'hA0 : 32'hB0);
      step();
      chk("rr_m0_rvalid", {31'd0, m0_rv}, {31'd0, e0});
      chk("rr_m1_rvalid", {31'd0, m1_rv}, {31'd0, !e0});
      if (e0) chk("rr_m0_rdata", m0_rd, 32'h100 + 32'(i));
      else    chk("rr_m1_rdata", m1_rd, 32'h100 + 32'(i));
    end
    m0_req = 0; m1_req = 0;
    step();
    chk("rr_quiet_rv", {30'd0, m1_rv, m0_rv}, 32'd0);
    chk("rr_m0_hold", m0_rd, 32'h104);
    chk("rr_m1_hold", m1_rd, 32'h105);

    // m1 store with m0 idle
    m1_req = 1; m1_addr = 32'h7000; m1_wdata = 32'h55;
    m1_wren = 1; m1_st = 2'd2;
    @(negedge clk);
    chk("st_m1_gnt", {31'd0, m1_gnt}, 32'd1);
    chk("st_wren", {31'd0, lsu_wren}, 32'd1);
    chk("st_data", st_data, 32'h55);
    chk("st_addr", lsu_addr, 32'h7000);
    chk("st_stype", {30'd0, store_type}, 32'd2);
    step();
    m1_req = 0; m1_wren = 0; m1_st = 0;
    chk("st_no_rvalid", {30'd0, m1_rv, m0_rv}, 32'd0);
    @(negedge clk);
    chk("st_wren_off", {31'd0, lsu_wren}, 32'd0);
    chk("st_data_off", st_data, 32'd0);
    step();

`ifdef LSU_ARB_LOCK_EN
    // m0 holds lock: forced release after 4 grants
    m0_req = 1; m0_lock = 1; m1_req = 1;
    m0_addr = 32'hC0; m1_addr = 32'hD0;
    for (int i = 0; i < 5; i++) begin
      logic e0;
      e0 = (i < 4);
      @(negedge clk);
      chk("lk_m0_gnt", {31'd0, m0_gnt}, {31'd0, e0});
      chk("lk_m1_gnt", {31'd0, m1_gnt}, {31'd0, !e0});
      step();
    end
    m0_req = 0; m0_lock = 0; m1_req = 0;

    // m1 locks, drops lock on its third grant
    m1_req = 1; m1_lock = 1;
    @(negedge clk);
    chk("ul_c1_m1_gnt", {31'd0, m1_gnt}, 32'd1);
    step();
    m0_req = 1;
    @(negedge clk);
    chk("ul_c2_m1_gnt", {31'd0, m1_gnt}, 32'd1);
    chk("ul_c2_m0_gnt", {31'd0, m0_gnt}, 32'd0);
    step();
    m1_lock = 0;
    @(negedge clk);
    chk("ul_c3_m1_gnt", {31'd0, m1_gnt}, 32'd1);
    chk("ul_c3_m0_gnt", {31'd0, m0_gnt}, 32'd0);
    step();
    @(negedge clk);
    chk("ul_c4_m0_gnt", {31'd0, m0_gnt}, 32'd1);
    chk("ul_c4_m1_gnt", {31'd0, m1_gnt}, 32'd0);
    step();
    m0_req = 0; m1_req = 0;
`else
    // lock inputs ignored: plain alternation
    m0_req = 1; m0_lock = 1; m1_req = 1; m1_lock = 1;
    for (int i = 0; i < 3; i++) begin
      logic e0;
      e0 = (i % 2 == 0);
      @(negedge clk);
      chk("nl_m0_gnt", {31'd0, m0_gnt}, {31'd0, e0});
      chk("nl_m1_gnt", {31'd0, m1_gnt}, {31'd0, !e0});
      step();
    end
    m0_req = 0; m0_lock = 0; m1_req = 0; m1_lock = 0;
`endif

    // async reset right after a granted load
    m0_req = 1; m0_addr = 32'h20; ld_data = 32'h1234_5678;
    @(negedge clk);
    chk("ar_m0_gnt", {31'd0, m0_gnt}, 32'd1);
    step();
    m0_req = 0;
    chk("ar_pre_rvalid", {31'd0, m0_rv}, 32'd1);
    chk("ar_pre_rdata", m0_rd, 32'h1234_5678);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_rvalid0", {31'd0, m0_rv}, 32'd0);
    chk("ar_rdata0", m0_rd, 32'd0);
    chk("ar_rdata1", m1_rd, 32'd0);
    rst = 1'b0;
    m0_req = 1; m1_req = 1;
    @(negedge clk);
    chk("ar_conf_m0", {31'd0, m0_gnt}, 32'd1);
    chk("ar_conf_m1", {31'd0, m1_gnt}, 32'd0);
    step();
    chk("ar_post_rv0", {31'd0, m0_rv}, 32'd1);
    chk("ar_post_rv1", {31'd0, m1_rv}, 32'd0);
    m0_req = 0; m1_req = 0;
    step();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
